// File: rtl/rom_stream_pkg.sv
// Shared types, glyph encodings and message table for the display-pattern ROM stream.
package rom_stream_pkg;

    localparam int unsigned GLYPH_W   = 7;
    localparam int unsigned WORD_W    = 2 * GLYPH_W + 2;
    localparam int unsigned MSG_WORDS = 6;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        FIN
    } state_t;

    // 7-segment encodings, bit order gfedcba
    localparam logic [GLYPH_W-1:0] G_0     = 7'h3F;
    localparam logic [GLYPH_W-1:0] G_1     = 7'h06;
    localparam logic [GLYPH_W-1:0] G_2     = 7'h5B;
    localparam logic [GLYPH_W-1:0] G_3     = 7'h4F;
    localparam logic [GLYPH_W-1:0] G_4     = 7'h66;
    localparam logic [GLYPH_W-1:0] G_5     = 7'h6D;
    localparam logic [GLYPH_W-1:0] G_6     = 7'h7D;
    localparam logic [GLYPH_W-1:0] G_7     = 7'h07;
    localparam logic [GLYPH_W-1:0] G_8     = 7'h7F;
    localparam logic [GLYPH_W-1:0] G_9     = 7'h6F;
    localparam logic [GLYPH_W-1:0] G_L     = 7'h38;
    localparam logic [GLYPH_W-1:0] G_O     = 7'h3F;
    localparam logic [GLYPH_W-1:0] G_V     = 7'h3E;
    localparam logic [GLYPH_W-1:0] G_E     = 7'h79;
    localparam logic [GLYPH_W-1:0] G_Y     = 7'h6E;
    localparam logic [GLYPH_W-1:0] G_U     = 7'h3E;
    localparam logic [GLYPH_W-1:0] G_BLANK = 7'h00;

    function automatic logic [WORD_W-1:0] pack(input logic [GLYPH_W-1:0] hi,
                                               input logic [GLYPH_W-1:0] lo);
        return {2'b00, hi, lo};
    endfunction

    // Message "13 14 LO VE  Y OU"; anything past the message reads blank
    function automatic logic [WORD_W-1:0] msg_word(input int unsigned idx);
        case (idx)
            0:       return pack(G_1, G_3);
            1:       return pack(G_1, G_4);
            2:       return pack(G_L, G_O);
            3:       return pack(G_V, G_E);
            4:       return pack(G_BLANK, G_Y);
            5:       return pack(G_O, G_U);
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/rom_table.sv
// Combinational dual-read lookup over the constant glyph-pair table.
module rom_table
    import rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SEG_W   = 7,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MSG_LEN = 6
) (
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] data_a_c,
    output logic [DATA_W-1:0] data_b_c
);

    // Re-pack each stored glyph pair into the configured glyph width
    function automatic logic [DATA_W-1:0] lookup(input logic [ADDR_W-1:0] a);
        logic [WORD_W-1:0]  w;
        logic [GLYPH_W-1:0] hi;
        logic [GLYPH_W-1:0] lo;
        w  = '0;
        if (32'(a) < MSG_LEN) begin
            w = msg_word(32'(a));
        end
        hi = w[2*GLYPH_W-1:GLYPH_W];
        lo = w[GLYPH_W-1:0];
        return DATA_W'({SEG_W'(hi), SEG_W'(lo)});
    endfunction

    assign data_a_c = lookup(addr_a);
    assign data_b_c = lookup(addr_b);

endmodule

// File: rtl/rom_stream.sv
// Glyph-pair ROM with a chip-selected random read port and a valid/ready burst-stream engine.
module rom_stream
    import rom_stream_pkg::*;
#(
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned SEG_W   = 7,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MSG_LEN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cs,
    input  logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   burst_len,
    input  logic              wrap_en,
    input  logic              stop,
    output logic [DATA_W-1:0] s_data,
    output logic              s_valid,
    input  logic              s_ready,
    output logic              s_last,
    output logic              busy,
    output logic              done
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic [ADDR_W-1:0] base, base_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [CNT_W-1:0]  len, len_nxt;
    logic              wrap, wrap_nxt;
    logic              s_valid_nxt;
    logic              s_last_nxt;
    logic [DATA_W-1:0] rand_word_c;
    logic [DATA_W-1:0] stream_word_c;

    // Stream side looks up the word it will present next cycle
    rom_table #(
        .DATA_W  (DATA_W),
        .SEG_W   (SEG_W),
        .ADDR_W  (ADDR_W),
        .MSG_LEN (MSG_LEN)
    ) u_table (
        .addr_a   (address),
        .addr_b   (ptr_nxt),
        .data_a_c (rand_word_c),
        .data_b_c (stream_word_c)
    );

    // Random-access port, independent of the engine
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= cs;
            if (cs) begin
                data_out <= rand_word_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            base    <= '0;
            cnt     <= '0;
            len     <= '0;
            wrap    <= 1'b0;
            s_data  <= '0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            base    <= base_nxt;
            cnt     <= cnt_nxt;
            len     <= len_nxt;
            wrap    <= wrap_nxt;
            s_valid <= s_valid_nxt;
            s_last  <= s_last_nxt;
            busy    <= (state_nxt != IDLE);
            done    <= (state_nxt == FIN);
            if (s_valid_nxt) begin
                s_data <= stream_word_c;
            end
        end
    end

    // cnt counts beats left in the pass, including the one on the bus
    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        base_nxt    = base;
        cnt_nxt     = cnt;
        len_nxt     = len;
        wrap_nxt    = wrap;
        s_valid_nxt = s_valid;
        s_last_nxt  = s_last;

        case (state)
            IDLE: begin
                if (start) begin
                    base_nxt = base_addr;
                    len_nxt  = burst_len;
                    wrap_nxt = wrap_en;
                    if (burst_len == '0) begin
                        state_nxt = FIN;
                    end else begin
                        state_nxt   = STREAM;
                        ptr_nxt     = base_addr;
                        cnt_nxt     = burst_len;
                        s_valid_nxt = 1'b1;
                        s_last_nxt  = (burst_len == CNT_W'(1));
                    end
                end
            end
            STREAM: begin
                if (stop) begin
                    state_nxt   = IDLE;
                    s_valid_nxt = 1'b0;
                    s_last_nxt  = 1'b0;
                end else if (s_valid && s_ready) begin
                    if (cnt > CNT_W'(1)) begin
                        ptr_nxt    = ptr + ADDR_W'(1);
                        cnt_nxt    = cnt - CNT_W'(1);
                        s_last_nxt = (cnt == CNT_W'(2));
                    end else if (wrap) begin
                        ptr_nxt    = base;
                        cnt_nxt    = len;
                        s_last_nxt = (len == CNT_W'(1));
                    end else begin
                        state_nxt   = FIN;
                        s_valid_nxt = 1'b0;
                        s_last_nxt  = 1'b0;
                    end
                end
            end
            FIN: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                s_valid_nxt = 1'b0;
                s_last_nxt  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rom_stream.sv
// Bench for rom_stream: queue-based reference model checked every cycle, plus directed literal checks.
module tb_rom_stream;

    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 10;
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst, cs, start, wrap_en, stop, s_ready;
    logic [AW-1:0] address, base_addr;
    logic [AW:0]   burst_len;
    logic [DW-1:0] data_out, s_data;
    logic          rd_valid, s_valid, s_last, busy, done;

    always #5 clk = ~clk;

    rom_stream dut (
        .clk       (clk),
        .rst       (rst),
        .cs        (cs),
        .address   (address),
        .data_out  (data_out),
        .rd_valid  (rd_valid),
        .start     (start),
        .base_addr (base_addr),
        .burst_len (burst_len),
        .wrap_en   (wrap_en),
        .stop      (stop),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_last    (s_last),
        .busy      (busy),
        .done      (done)
    );

    int n_vec = 0;
    int n_err = 0;
    int n_done = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: ROM image plus a queue holding the words still owed in the current pass
    logic [DW-1:0] rom_m [DEPTH];
    logic [DW-1:0] q [$];
    bit            m_active, m_fin, m_wrap, m_rdv, started;
    int            m_base, m_len;
    logic [DW-1:0] m_dout, m_sdata;

    function automatic void refill();
        for (int i = 0; i < m_len; i++) q.push_back(rom_m[(m_base + i) % DEPTH]);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            started  = 1'b1;
            q.delete();
            m_active = 1'b0;
            m_fin    = 1'b0;
            m_rdv    = 1'b0;
            m_dout   = '0;
            m_sdata  = '0;
        end else begin
            if (cs) m_dout = rom_m[address];
            m_rdv = cs;
            if (m_fin) begin
                m_fin = 1'b0;
            end else if (m_active) begin
                if (stop) begin
                    m_active = 1'b0;
                    q.delete();
                end else if (s_ready) begin
                    void'(q.pop_front());
                    if (q.size() == 0) begin
                        if (m_wrap) refill();
                        else begin
                            m_active = 1'b0;
                            m_fin    = 1'b1;
                        end
                    end
                end
            end else if (start) begin
                m_base = int'(base_addr);
                m_len  = int'(burst_len);
                m_wrap = wrap_en;
                if (m_len == 0) m_fin = 1'b1;
                else begin
                    refill();
                    m_active = 1'b1;
                end
            end
            if (m_active) m_sdata = q[0];
        end
    end

    logic [DW-1:0] rx_d [$];
    logic          rx_l [$];

    // Every-cycle compare against the model; also logs beats handed to the consumer
    always @(negedge clk) begin
        if (started) begin
            chk("data_out", 32'(data_out), 32'(m_dout));
            chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
            chk("s_valid", 32'(s_valid), 32'(m_active));
            chk("s_last", 32'(s_last), 32'(m_active && q.size() == 1));
            chk("busy", 32'(busy), 32'(m_active || m_fin));
            chk("done", 32'(done), 32'(m_fin));
            if (m_active) chk("s_data", 32'(s_data), 32'(m_sdata));
            if (s_valid && s_ready) begin
                rx_d.push_back(s_data);
                rx_l.push_back(s_last);
            end
            if (done) n_done++;
        end
    end

    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic burst(input int b, input int l, input bit w);
        base_addr = AW'(b);
        burst_len = LW'(l);
        wrap_en   = w;
        start     = 1'b1;
        cyc();
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int lim);
        for (int i = 0; i < lim && busy; i++) cyc();
        chk("idle_timeout", 32'(busy), 32'(0));
    endtask

    task automatic exp_beat(input int i, input logic [DW-1:0] d, input logic l);
        if (i < rx_d.size()) begin
            chk("beat_data", 32'(rx_d[i]), 32'(d));
            chk("beat_last", 32'(rx_l[i]), 32'(l));
        end else begin
            chk("beat_missing", 32'(rx_d.size()), 32'(i + 1));
        end
    endtask

    task automatic clear_rx();
        rx_d.delete();
        rx_l.delete();
    endtask

    int nd0;
    bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    initial begin
        for (int i = 0; i < int'(DEPTH); i++) rom_m[i] = '0;
        rom_m[0] = 16'h034F;
        rom_m[1] = 16'h0366;
        rom_m[2] = 16'h1C3F;
        rom_m[3] = 16'h1F79;
        rom_m[4] = 16'h006E;
        rom_m[5] = 16'h1FBE;

        rst = 1'b1; cs = 1'b1; address = AW'(2); start = 1'b1;
        base_addr = '0; burst_len = LW'(6); wrap_en = 1'b0; stop = 1'b0; s_ready = 1'b1;
        cyc(2);
        chk("rst_data_out", 32'(data_out), 32'(0));
        chk("rst_rd_valid", 32'(rd_valid), 32'(0));
        chk("rst_s_valid", 32'(s_valid), 32'(0));
        chk("rst_s_last", 32'(s_last), 32'(0));
        chk("rst_s_data", 32'(s_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));

        rst = 1'b0; start = 1'b0;
        cyc();
        chk("rd_addr2", 32'(data_out), 32'h1C3F);
        chk("rd_addr2_valid", 32'(rd_valid), 32'(1));
        cs = 1'b0;

        // Full message, consumer always ready
        clear_rx(); nd0 = n_done;
        burst(0, 6, 1'b0);
        chk("full_first_valid", 32'(s_valid), 32'(1));
        wait_idle(50);
        exp_beat(0, 16'h034F, 1'b0);
        exp_beat(1, 16'h0366, 1'b0);
        exp_beat(2, 16'h1C3F, 1'b0);
        exp_beat(3, 16'h1F79, 1'b0);
        exp_beat(4, 16'h006E, 1'b0);
        exp_beat(5, 16'h1FBE, 1'b1);
        chk("full_count", 32'(rx_d.size()), 32'(6));
        chk("full_done", 32'(n_done - nd0), 32'(1));

        // Backpressure
        clear_rx();
        burst(2, 3, 1'b0);
        for (int i = 0; i < 6; i++) begin
            s_ready = pat[i];
            cyc();
        end
        s_ready = 1'b1;
        wait_idle(50);
        exp_beat(0, 16'h1C3F, 1'b0);
        exp_beat(1, 16'h1F79, 1'b0);
        exp_beat(2, 16'h006E, 1'b1);
        chk("bp_count", 32'(rx_d.size()), 32'(3));

        // Looping pass aborted on an accepted beat
        clear_rx(); nd0 = n_done;
        burst(4, 2, 1'b1);
        cyc(5);
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        chk("stop_valid", 32'(s_valid), 32'(0));
        chk("stop_busy", 32'(busy), 32'(0));
        cyc(2);
        chk("stop_no_done", 32'(n_done - nd0), 32'(0));
        for (int i = 0; i < 6; i++)
            exp_beat(i, (i % 2 == 0) ? 16'h006E : 16'h1FBE, (i % 2 == 1));
        chk("wrap_count", 32'(rx_d.size()), 32'(6));

        // Zero-length burst
        nd0 = n_done;
        burst(0, 0, 1'b0);
        chk("len0_done", 32'(done), 32'(1));
        chk("len0_valid", 32'(s_valid), 32'(0));
        chk("len0_busy", 32'(busy), 32'(1));
        cyc();
        chk("len0_done_clr", 32'(done), 32'(0));
        chk("len0_idle", 32'(busy), 32'(0));
        chk("len0_pulses", 32'(n_done - nd0), 32'(1));

        // Address rollover
        clear_rx();
        burst(1023, 3, 1'b0);
        wait_idle(50);
        exp_beat(0, 16'h0000, 1'b0);
        exp_beat(1, 16'h034F, 1'b0);
        exp_beat(2, 16'h0366, 1'b1);
        chk("roll_count", 32'(rx_d.size()), 32'(3));

        // Ignored start while busy, random reads during the burst
        clear_rx();
        s_ready = 1'b0;
        burst(0, 4, 1'b0);
        cyc();
        burst(3, 1, 1'b0);
        cs = 1'b1; address = AW'(5);
        cyc();
        chk("conc_rd", 32'(data_out), 32'h1FBE);
        chk("conc_rd_valid", 32'(rd_valid), 32'(1));
        s_ready = 1'b1;
        wait_idle(50);
        cs = 1'b0;
        exp_beat(0, 16'h034F, 1'b0);
        exp_beat(1, 16'h0366, 1'b0);
        exp_beat(2, 16'h1C3F, 1'b0);
        exp_beat(3, 16'h1F79, 1'b1);
        chk("conc_count", 32'(rx_d.size()), 32'(4));

        // Randomised traffic against the model
        for (int k = 0; k < 1500; k++) begin
            rst     = ($urandom_range(99) == 0);
            start   = ($urandom_range(7) == 0);
            case ($urandom_range(2))
                0:       base_addr = AW'($urandom_range(7));
                1:       base_addr = AW'(1020 + $urandom_range(3));
                default: base_addr = AW'($urandom);
            endcase
            burst_len = ($urandom_range(49) == 0) ? LW'(1030) : LW'($urandom_range(9));
            wrap_en   = ($urandom_range(3) == 0);
            stop      = ($urandom_range(15) == 0);
            s_ready   = ($urandom_range(9) < 7);
            cs        = $urandom_range(1) == 1;
            address   = ($urandom_range(1) == 1) ? AW'($urandom_range(9)) : AW'($urandom);
            cyc();
        end
        rst = 1'b0; start = 1'b0; cs = 1'b0; stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc(3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
